eth_tx_frame_sched: RTL and testbench
=====================================

Name: eth_tx_frame_sched

Overview:
Sequences fixed-length Ethernet frames from the payload memory into the MAC transmit FIFO interface (ff_tx_*).
- Gated by Ethernet config completion and a frame trigger pulse (e.g. the clock divider pulse).
- Issues memory reads and buffers returned words in a 2-entry buffer.
- Drives SOP/EOP/MOD framing and honours MAC backpressure (ff_tx_rdy).
- Enforces an inter-frame gap and keeps frame and drop statistics.

Parameters:
FRAME_WORDS, 16, 32-bit words per frame; range 2..2**ADDR_W.
ADDR_W, 8, payload memory address width.
LAST_MOD, 0, value on ff_tx_mod with EOP (count of invalid bytes in the last word).
IFG_CYCLES, 12, idle clocks after EOP acceptance before the next frame may start; range 1..255.

Ports:
clk_hifreq  in  1  system clock; all logic on rising edge.
rst  in  1  asynchronous, active-high reset.
cfg_done  in  1  high once MAC register configuration has finished.
trigger  in  1  single-cycle frame request.
mem_rd_en  out  1  payload memory read strobe.
mem_addr  out  ADDR_W  payload read address; data returns exactly 1 cycle after mem_rd_en.
mem_data  in  32  payload read data.
ff_tx_data  out  32  MAC FIFO write data.
ff_tx_wren  out  1  MAC FIFO write valid.
ff_tx_sop  out  1  first word of frame; qualified by wren.
ff_tx_eop  out  1  last word of frame; qualified by wren.
ff_tx_mod  out  2  invalid-byte count on EOP word.
ff_tx_err  out  1  frame error; tied 0.
ff_tx_rdy  in  1  MAC FIFO ready.
busy  out  1  high whenever state is not IDLE.
frame_cnt  out  16  frames completed.
drop_cnt  out  8  triggers ignored.

Behaviour:
- Reset (async assert, release synchronous to clk_hifreq):
  - State IDLE.
  - Buffer emptied; in-flight read flag cleared.
  - All outputs 0; frame_cnt = 0, drop_cnt = 0.
- Reset asserted mid-frame aborts immediately; no EOP is emitted.
- States:
  - IDLE: trigger && cfg_done -> SEND (next cycle). Word indices rd_idx = 0 and tx_idx = 0.
  - SEND: exits to IFG in the cycle the EOP word is accepted (wren && rdy && eop). IFG counter loads IFG_CYCLES.
  - IFG: counter decrements each cycle; at 1 -> IDLE.
- Read issue:
  - mem_rd_en = 1 in a SEND cycle iff rd_idx < FRAME_WORDS and (buffer occupancy + in-flight) < 2.
  - Occupancy is counted after any pop in the same cycle.
  - mem_addr = rd_idx (zero-extended); rd_idx increments on each issue.
  - mem_rd_en and mem_addr are combinational from registered state.
- Buffer: 2-entry FIFO.
  - mem_data is written on the cycle after mem_rd_en.
  - Push and pop may occur in the same cycle.
  - Overflow is impossible by the issue rule.
- MAC side:
  - ff_tx_wren = buffer non-empty; ff_tx_data = head entry.
  - ff_tx_sop = wren && tx_idx == 0.
  - ff_tx_eop = wren && tx_idx == FRAME_WORDS-1.
  - ff_tx_mod = LAST_MOD when eop, else 0.
  - Word accepted when wren && rdy: pop, tx_idx++.
  - While rdy = 0, data and flags hold stable.
- Latency: trigger at cycle T (IDLE, cfg_done = 1, rdy = 1) -> first mem_rd_en at T+1 -> first wren with sop at T+2.
  - With rdy held high, one word is accepted per cycle.
  - EOP is accepted at T+1+FRAME_WORDS.
- Counters:
  - frame_cnt increments on EOP acceptance; wraps at 2^16.
  - drop_cnt increments (saturating at 255) on trigger while busy, or trigger in IDLE with cfg_done = 0.
- cfg_done falling mid-frame: ignored; the current frame completes.
- Trigger on the same cycle as the IFG->IDLE transition is dropped, because the state is still IFG.

Optional Feature:
TX_AUTOREPEAT_EN.
- Defined: at IFG expiry, if cfg_done = 1, go directly to SEND (indices reset) without a trigger. Frames stream back-to-back with exactly IFG_CYCLES idle clocks between EOP acceptance and the next first read. Triggers while busy still increment drop_cnt.
- Undefined: IFG -> IDLE only, as described above.

Test Plan:
- cfg_done = 0, trigger pulse -> no mem_rd_en; drop_cnt = 1, busy = 0.
- cfg_done = 1, rdy = 1, trigger at cycle 10, FRAME_WORDS = 16, mem_data = addr+0xA000 -> wren cycles 12..27 with data 0xA000..0xA00F; sop at 12, eop at 27, mod = 0; frame_cnt = 1; busy falls at 40.
- rdy toggled 1,0,0,1 repeating during a frame -> no word lost or duplicated; data/sop/eop stable while rdy = 0; exactly 16 accepted words; ≤2 outstanding reads+buffered.
- Trigger at cycles 10 and 15 -> one frame only; drop_cnt = 1.
- rst asserted at the 5th accepted word -> all outputs 0 in the same cycle (async); after release and a new trigger, the frame starts at mem_addr 0 with sop.
- TX_AUTOREPEAT_EN, single trigger, rdy = 1 -> consecutive frames with 12 idle cycles between EOP and next read; frame_cnt increments per frame.

Source files
------------

// File: rtl/eth_tx_frame_sched.sv
// Streams fixed-length frames from payload memory into the MAC ff_tx FIFO interface.
// Optional macro TX_AUTOREPEAT_EN: restart the next frame automatically when the inter-frame gap expires.
module eth_tx_frame_sched #(
  parameter int         FRAME_WORDS = 16,
  parameter int         ADDR_W      = 8,
  parameter logic [1:0] LAST_MOD    = 2'd0,
  parameter int         IFG_CYCLES  = 12
) (
  input  logic              clk_hifreq,
  input  logic              rst,
  input  logic              cfg_done,
  input  logic              trigger,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_data,
  output logic [31:0]       ff_tx_data,
  output logic              ff_tx_wren,
  output logic              ff_tx_sop,
  output logic              ff_tx_eop,
  output logic [1:0]        ff_tx_mod,
  output logic              ff_tx_err,
  input  logic              ff_tx_rdy,
  output logic              busy,
  output logic [15:0]       frame_cnt,
  output logic [7:0]        drop_cnt
);

  localparam int              IDX_W     = ADDR_W + 1;
  localparam logic [IDX_W-1:0] NUM_WORDS = IDX_W'(FRAME_WORDS);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(FRAME_WORDS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    IFG  = 2'd2
  } state_e;

  state_e           state_q;
  logic [IDX_W-1:0] rd_idx_q;
  logic [IDX_W-1:0] tx_idx_q;
  logic [7:0]       ifg_q;
  logic [15:0]      frame_q;
  logic [7:0]       drop_q;

  logic [1:0]  cnt_q, cnt_d;
  logic        inflight_q, inflight_d;
  logic [31:0] buf0_q, buf0_d;
  logic [31:0] buf1_q, buf1_d;

  logic [1:0]  occ;
  logic [1:0]  occ_after;
  logic [31:0] head;
  logic        wren;
  logic        pop;
  logic        last_word;
  logic        eop_accept;
  logic        issue;

  // The word returning from memory counts as a buffer entry in its arrival
  // cycle and is shown on the FIFO head directly, so SOP follows the first read by one cycle.
  always_comb begin
    occ        = cnt_q + {1'b0, inflight_q};
    head       = (cnt_q != 2'd0) ? buf0_q : mem_data;
    wren       = (occ != 2'd0);
    pop        = wren && ff_tx_rdy;
    occ_after  = occ - {1'b0, pop};
    last_word  = (tx_idx_q == LAST_IDX);
    eop_accept = pop && last_word;
    issue      = (state_q == SEND) && (rd_idx_q < NUM_WORDS) && (occ_after < 2'd2);

    inflight_d = issue;
    cnt_d      = occ_after;
    buf0_d     = buf0_q;
    buf1_d     = buf1_q;
    if (pop) begin
      if (cnt_q == 2'd2) begin
        buf0_d = buf1_q;
      end else if (cnt_q == 2'd1 && inflight_q) begin
        buf0_d = mem_data;
      end
    end else if (inflight_q) begin
      if (cnt_q == 2'd0) begin
        buf0_d = mem_data;
      end else begin
        buf1_d = mem_data;
      end
    end
  end

  always_ff @(posedge clk_hifreq or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      rd_idx_q   <= '0;
      tx_idx_q   <= '0;
      ifg_q      <= '0;
      frame_q    <= '0;
      drop_q     <= '0;
      cnt_q      <= '0;
      inflight_q <= 1'b0;
      buf0_q     <= '0;
      buf1_q     <= '0;
    end else begin
      cnt_q      <= cnt_d;
      inflight_q <= inflight_d;
      buf0_q     <= buf0_d;
      buf1_q     <= buf1_d;

      if (issue) begin
        rd_idx_q <= rd_idx_q + 1'b1;
      end
      if (pop) begin
        tx_idx_q <= tx_idx_q + 1'b1;
      end
      if (eop_accept) begin
        frame_q <= frame_q + 16'd1;
      end
      if (trigger && (state_q != IDLE || !cfg_done) && drop_q != 8'hFF) begin
        drop_q <= drop_q + 8'd1;
      end

      case (state_q)
        IDLE: begin
          if (trigger && cfg_done) begin
            state_q  <= SEND;
            rd_idx_q <= '0;
            tx_idx_q <= '0;
          end
        end
        SEND: begin
          if (eop_accept) begin
            state_q <= IFG;
            ifg_q   <= 8'(IFG_CYCLES);
          end
        end
        IFG: begin
          if (ifg_q == 8'd1) begin
`ifdef TX_AUTOREPEAT_EN
            if (cfg_done) begin
              state_q  <= SEND;
              rd_idx_q <= '0;
              tx_idx_q <= '0;
            end else begin
              state_q <= IDLE;
            end
`else
            state_q <= IDLE;
`endif
          end else begin
            ifg_q <= ifg_q - 8'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_rd_en  = issue;
  assign mem_addr   = rd_idx_q[ADDR_W-1:0];
  assign ff_tx_wren = wren;
  assign ff_tx_data = wren ? head : 32'd0;
  assign ff_tx_sop  = wren && (tx_idx_q == '0);
  assign ff_tx_eop  = wren && last_word;
  assign ff_tx_mod  = (wren && last_word) ? LAST_MOD : 2'd0;
  assign ff_tx_err  = 1'b0;
  assign busy       = (state_q != IDLE);
  assign frame_cnt  = frame_q;
  assign drop_cnt   = drop_q;

endmodule

// File: tb/tb_eth_tx_frame_sched.sv
// Directed bench for eth_tx_frame_sched: vector table for a full frame plus hand sequences.
// Honours TX_AUTOREPEAT_EN to choose the post-gap expectations.
module tb_eth_tx_frame_sched;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_done = 1'b0;
  logic        trigger = 1'b0;
  logic        ff_tx_rdy = 1'b1;
  logic [31:0] mem_data = 32'd0;
  logic        mem_rd_en;
  logic [7:0]  mem_addr;
  logic [31:0] ff_tx_data;
  logic        ff_tx_wren, ff_tx_sop, ff_tx_eop, ff_tx_err, busy;
  logic [1:0]  ff_tx_mod;
  logic [15:0] frame_cnt;
  logic [7:0]  drop_cnt;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        trig;
    logic        rden;
    logic [7:0]  addr;
    logic        wren;
    logic        sop;
    logic        eop;
    logic [31:0] data;
    logic        bsy;
    logic [15:0] frames;
    logic [7:0]  drops;
  } vec_t;

  vec_t tbl [40];

  eth_tx_frame_sched #(
    .FRAME_WORDS(16),
    .ADDR_W(8),
    .LAST_MOD(2'd0),
    .IFG_CYCLES(12)
  ) dut (
    .clk_hifreq(clk),
    .rst(rst),
    .cfg_done(cfg_done),
    .trigger(trigger),
    .mem_rd_en(mem_rd_en),
    .mem_addr(mem_addr),
    .mem_data(mem_data),
    .ff_tx_data(ff_tx_data),
    .ff_tx_wren(ff_tx_wren),
    .ff_tx_sop(ff_tx_sop),
    .ff_tx_eop(ff_tx_eop),
    .ff_tx_mod(ff_tx_mod),
    .ff_tx_err(ff_tx_err),
    .ff_tx_rdy(ff_tx_rdy),
    .busy(busy),
    .frame_cnt(frame_cnt),
    .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  // Payload memory: one-cycle read latency, contents are address + 0xA000.
  always @(posedge clk) begin
    if (mem_rd_en) mem_data <= 32'hA000 + {24'd0, mem_addr};
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic trig, input logic cfg, input logic rdy);
    trigger   = trig;
    cfg_done  = cfg;
    ff_tx_rdy = rdy;
  endtask

  // Leaves the bench inside the window of cycle 0, reset just released.
  task automatic doReset();
    @(negedge clk);
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, " wren"}, ff_tx_wren, 0);
    checkOutput({tag, " rd_en"}, mem_rd_en, 0);
    checkOutput({tag, " sop"}, ff_tx_sop, 0);
    checkOutput({tag, " eop"}, ff_tx_eop, 0);
    checkOutput({tag, " data"}, ff_tx_data, 0);
    checkOutput({tag, " busy"}, busy, 0);
    checkOutput({tag, " frame_cnt"}, frame_cnt, 0);
    checkOutput({tag, " drop_cnt"}, drop_cnt, 0);
    checkOutput({tag, " err"}, ff_tx_err, 0);
  endtask

  initial begin
    int accepted, sops, issued, maxOut, k;
    logic prevHold, prevSop, prevEop;
    logic [31:0] prevData;
    logic [3:0] rdyPat;
    logic sawRead;

    for (int c = 0; c < 40; c++) begin
      tbl[c].trig   = (c == 10) || (c == 39);
      tbl[c].rden   = (c >= 11) && (c <= 26);
      tbl[c].addr   = 8'(c - 11);
      tbl[c].wren   = (c >= 12) && (c <= 27);
      tbl[c].sop    = (c == 12);
      tbl[c].eop    = (c == 27);
      tbl[c].data   = tbl[c].wren ? 32'hA000 + 32'(c - 12) : 32'd0;
      tbl[c].bsy    = (c >= 11) && (c <= 39);
      tbl[c].frames = (c >= 28) ? 16'd1 : 16'd0;
      tbl[c].drops  = 8'd0;
    end

    // Reset state while reset is held
    @(negedge clk);
    #1;
    checkAllZero("reset");

    // Trigger without cfg_done is dropped
    doReset();
    applyStimulus(1'b1, 1'b0, 1'b1);
    #1;
    checkOutput("nocfg rd_en c0", mem_rd_en, 0);
    sawRead = 1'b0;
    for (int c = 1; c < 5; c++) begin
      @(negedge clk);
      applyStimulus(1'b0, 1'b0, 1'b1);
      #1;
      if (mem_rd_en || busy) sawRead = 1'b1;
    end
    checkOutput("nocfg activity", sawRead, 0);
    checkOutput("nocfg drop_cnt", drop_cnt, 1);
    checkOutput("nocfg busy", busy, 0);

    // Full frame from the vector table, with a trigger on the last IFG cycle
    doReset();
    for (int c = 0; c < 40; c++) begin
      if (c > 0) @(negedge clk);
      applyStimulus(tbl[c].trig, 1'b1, 1'b1);
      #1;
      checkOutput($sformatf("cyc%0d rd_en", c), mem_rd_en, tbl[c].rden);
      if (tbl[c].rden) checkOutput($sformatf("cyc%0d addr", c), mem_addr, tbl[c].addr);
      checkOutput($sformatf("cyc%0d wren", c), ff_tx_wren, tbl[c].wren);
      checkOutput($sformatf("cyc%0d sop", c), ff_tx_sop, tbl[c].sop);
      checkOutput($sformatf("cyc%0d eop", c), ff_tx_eop, tbl[c].eop);
      checkOutput($sformatf("cyc%0d mod", c), ff_tx_mod, 0);
      checkOutput($sformatf("cyc%0d data", c), ff_tx_data, tbl[c].data);
      checkOutput($sformatf("cyc%0d busy", c), busy, tbl[c].bsy);
      checkOutput($sformatf("cyc%0d frame_cnt", c), frame_cnt, tbl[c].frames);
      checkOutput($sformatf("cyc%0d drop_cnt", c), drop_cnt, tbl[c].drops);
    end
    @(negedge clk);
    applyStimulus(1'b0, 1'b1, 1'b1);
    #1;
    checkOutput("cyc40 drop_cnt", drop_cnt, 1);
`ifdef TX_AUTOREPEAT_EN
    checkOutput("auto cyc40 rd_en", mem_rd_en, 1);
    checkOutput("auto cyc40 addr", mem_addr, 0);
    checkOutput("auto cyc40 busy", busy, 1);
    for (int c = 41; c <= 69; c++) begin
      @(negedge clk);
      applyStimulus(1'b0, 1'b1, 1'b1);
      #1;
      if (c == 41) checkOutput("auto cyc41 sop", ff_tx_sop, 1);
      if (c == 56) checkOutput("auto cyc56 eop", ff_tx_eop, 1);
      if (c == 56) checkOutput("auto cyc56 data", ff_tx_data, 32'hA00F);
      if (c == 57) checkOutput("auto cyc57 frame_cnt", frame_cnt, 2);
      if (c == 68) checkOutput("auto cyc68 rd_en", mem_rd_en, 0);
      if (c == 69) checkOutput("auto cyc69 rd_en", mem_rd_en, 1);
      if (c == 69) checkOutput("auto cyc69 addr", mem_addr, 0);
    end
`else
    checkOutput("cyc40 busy", busy, 0);
    checkOutput("cyc40 rd_en", mem_rd_en, 0);
    sawRead = 1'b0;
    for (int c = 41; c < 60; c++) begin
      @(negedge clk);
      applyStimulus(1'b0, 1'b1, 1'b1);
      #1;
      if (mem_rd_en || busy) sawRead = 1'b1;
    end
    checkOutput("no restart after gap", sawRead, 0);
`endif

    // Second trigger while busy is dropped
    doReset();
    accepted = 0;
    sops = 0;
    for (int c = 0; c < 46; c++) begin
      if (c > 0) @(negedge clk);
      applyStimulus((c == 10) || (c == 15), 1'b1, 1'b1);
      #1;
      if (ff_tx_wren && ff_tx_rdy) accepted++;
      if (ff_tx_wren && ff_tx_sop) sops++;
    end
    checkOutput("dbl accepted", accepted, 16);
    checkOutput("dbl sops", sops, 1);
    checkOutput("dbl frame_cnt", frame_cnt, 1);
    checkOutput("dbl drop_cnt", drop_cnt, 1);

    // Backpressure pattern 1,0,0,1
    doReset();
    rdyPat   = 4'b1001;
    accepted = 0;
    issued   = 0;
    maxOut   = 0;
    prevHold = 1'b0;
    prevSop  = 1'b0;
    prevEop  = 1'b0;
    prevData = 32'd0;
    k = 0;
    while (k < 200 && accepted < 16) begin
      if (k > 0) @(negedge clk);
      applyStimulus(k == 2, 1'b1, rdyPat[k % 4]);
      #1;
      if (issued - accepted > maxOut) maxOut = issued - accepted;
      if (prevHold) begin
        checkOutput($sformatf("bp hold wren k%0d", k), ff_tx_wren, 1);
        checkOutput($sformatf("bp hold data k%0d", k), ff_tx_data, prevData);
        checkOutput($sformatf("bp hold sop k%0d", k), ff_tx_sop, prevSop);
        checkOutput($sformatf("bp hold eop k%0d", k), ff_tx_eop, prevEop);
      end
      if (mem_rd_en) begin
        checkOutput($sformatf("bp addr k%0d", k), mem_addr, issued);
        issued++;
      end
      if (ff_tx_wren && ff_tx_rdy) begin
        checkOutput($sformatf("bp data w%0d", accepted), ff_tx_data, 32'hA000 + accepted);
        checkOutput($sformatf("bp sop w%0d", accepted), ff_tx_sop, accepted == 0);
        checkOutput($sformatf("bp eop w%0d", accepted), ff_tx_eop, accepted == 15);
        accepted++;
      end
      prevHold = ff_tx_wren && !ff_tx_rdy;
      prevData = ff_tx_data;
      prevSop  = ff_tx_sop;
      prevEop  = ff_tx_eop;
      k++;
    end
    @(negedge clk);
    applyStimulus(1'b0, 1'b1, 1'b1);
    #1;
    checkOutput("bp accepted", accepted, 16);
    checkOutput("bp issued", issued, 16);
    checkOutput("bp outstanding over 2", maxOut > 2, 0);
    checkOutput("bp frame_cnt", frame_cnt, 1);
    checkOutput("bp extra wren", ff_tx_wren, 0);

    // Reset asserted on the 5th accepted word
    doReset();
    for (int c = 0; c <= 16; c++) begin
      if (c > 0) @(negedge clk);
      applyStimulus(c == 10, 1'b1, 1'b1);
      #1;
    end
    checkOutput("mid 5th word data", ff_tx_data, 32'hA004);
    rst = 1'b1;
    #1;
    checkAllZero("mid reset");
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c <= 5; c++) begin
      if (c > 0) @(negedge clk);
      applyStimulus(c == 3, 1'b1, 1'b1);
      #1;
      if (c == 4) checkOutput("restart rd_en", mem_rd_en, 1);
      if (c == 4) checkOutput("restart addr", mem_addr, 0);
      if (c == 5) checkOutput("restart sop", ff_tx_sop, 1);
      if (c == 5) checkOutput("restart data", ff_tx_data, 32'hA000);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
